// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FSM encoding, parameter defaults and width helpers for the
// credit-based FIFO write arbiter.
package fifo_arb_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Credit counter must represent 0..DEPTH inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side bundle: per-requester valid, packed data words and the
// combinational one-hot grant returned by the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;

    modport master (
        output req,
        output wdata,
        input  gnt
    );

    modport slave (
        input  req,
        input  wdata,
        output gnt
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotating first-set search: lowest requesting index at or
// after ptr_i, wrapping to the lowest requesting index overall.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] hi_first;
    logic [N-1:0] all_first;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign hi_mask[gi] = (32'(ptr_i) <= gi);
        end
    endgenerate

    assign hi_req = req_i & hi_mask;

    // x & -x isolates the lowest set bit.
    assign hi_first  = hi_req & (~hi_req + N'(1));
    assign all_first = req_i & (~req_i + N'(1));

    assign gnt_o   = (hi_req != '0) ? hi_first : all_first;
    assign valid_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter feeding a downstream sync FIFO; admission is
// gated by a free-slot credit counter replenished by fifo_rd_i pulses.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NREQ      = DEF_NREQ,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    fifo_wr_arbiter_if.slave               req_if,
    output logic                           fifo_wr_en_o,
    output logic [WIDTH-1:0]               fifo_wdata_o,
    input  logic                           fifo_rd_i,
    output logic [credit_width(DEPTH)-1:0] credit_o,
    output logic                           err_o
);

    localparam int CW = credit_width(DEPTH);
    localparam int PW = idx_width(NREQ);
    localparam int KW = cnt_width(BURST_LEN);

    localparam logic [CW-1:0] CREDIT_FULL = CW'(DEPTH);
    localparam logic [KW-1:0] CNT_MAX     = KW'(BURST_LEN);
    localparam logic [PW-1:0] LAST_IDX    = PW'(NREQ - 1);

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [KW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    credit_q, credit_d;
    logic             err_q, err_d;
    logic             wr_en_q;
    logic [WIDTH-1:0] wdata_q;

    logic [NREQ-1:0]  pick_onehot;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic             credit_avail;
    logic             credit_full;
    logic             owner_req;
    logic             accept;
    logic [PW-1:0]    acc_idx;
    logic [WIDTH-1:0] acc_data;
    logic [NREQ-1:0]  gnt;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + PW'(1);
    endfunction

    rr_picker #(
        .N  (NREQ),
        .PW (PW)
    ) u_picker (
        .req_i   (req_if.req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_onehot),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (pick_onehot[n]) begin
                pick_idx = PW'(n);
            end
        end
    end

    assign credit_avail = (credit_q != '0);
    assign credit_full  = (credit_q == CREDIT_FULL);
    assign owner_req    = req_if.req[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        accept  = 1'b0;
        acc_idx = owner_q;

        case (state_q)
            IDLE: begin
                if (credit_avail && pick_valid) begin
                    gnt     = pick_onehot;
                    accept  = 1'b1;
                    acc_idx = pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = KW'(1);
                    if (BURST_LEN == 1) begin
                        ptr_d = wrap_inc(pick_idx);
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                // Exit cycle issues no grant so the next owner is chosen fresh.
                if (!owner_req || cnt_q >= CNT_MAX) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(owner_q);
                end else if (credit_avail) begin
                    gnt[owner_q] = 1'b1;
                    accept       = 1'b1;
                    cnt_d        = cnt_q + KW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst_i) begin
            gnt    = '0;
            accept = 1'b0;
        end
    end

    always_comb begin
        acc_data = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (acc_idx == PW'(n)) begin
                acc_data = req_if.wdata[n*WIDTH +: WIDTH];
            end
        end
    end

    // A return with the counter already full has no slot to free.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        case ({accept, fifo_rd_i})
            2'b10: credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_full) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            credit_q <= CREDIT_FULL;
            err_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            wr_en_q  <= accept;
            if (accept) begin
                wdata_q <= acc_data;
            end
        end
    end

    assign req_if.gnt   = gnt;
    assign fifo_wr_en_o = wr_en_q;
    assign fifo_wdata_o = wdata_q;
    assign credit_o     = credit_q;
    assign err_o        = err_q;

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_if.gnt));
    a_credit_range: assert property (@(posedge clk_i) disable iff (rst_i) credit_q <= CREDIT_FULL);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: grants checked per cycle, expected FIFO writes queued and
// matched by an independent monitor on the falling edge.
module tb_fifo_wr_arbiter;

    localparam int W = 4;
    localparam int D = 16;
    localparam int N = 4;
    localparam int B = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_rd;
    logic         wr_en;
    logic [W-1:0] wdata_o;
    logic [4:0]   credit;
    logic         err;

    int           n_cmp = 0;
    int           n_mis = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dat[N];
    logic [W-1:0] mon_exp;

    fifo_wr_arbiter_if #(.NREQ(N), .WIDTH(W)) rq ();

    fifo_wr_arbiter #(
        .WIDTH     (W),
        .DEPTH     (D),
        .NREQ      (N),
        .BURST_LEN (B)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_if       (rq),
        .fifo_wr_en_o (wr_en),
        .fifo_wdata_o (wdata_o),
        .fifo_rd_i    (fifo_rd),
        .credit_o     (credit),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, check grant at negedge, return at posedge+1.
    task automatic cyc(input logic [3:0] req, input logic rd, input logic r,
                       input logic [3:0] eg, input string tag);
        int idx;
        rq.req   = req;
        fifo_rd  = rd;
        rst      = r;
        rq.wdata = {dat[3], dat[2], dat[1], dat[0]};
        @(negedge clk);
        chk({tag, " gnt"}, 32'(rq.gnt), 32'(eg));
        idx = -1;
        for (int n = 0; n < N; n++) if (eg[n]) idx = n;
        if (idx >= 0) exp_q.push_back(dat[idx]);
        $display("cyc %-12s req=%b rd=%b rst=%b gnt=%b credit=%0d", tag, req, rd, r, rq.gnt, credit);
        @(posedge clk);
        #1;
        if (idx >= 0) dat[idx] = dat[idx] + 4'd1;
    endtask

    task automatic do_reset();
        cyc(4'b1111, 1'b0, 1'b1, 4'b0000, "rst");
        cyc(4'b1111, 1'b0, 1'b1, 4'b0000, "rst");
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL wr unexpected: got data %0d expected no write", wdata_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("wdata", 32'(wdata_o), 32'(mon_exp));
            end
        end
    end

    initial begin
        logic [3:0] eg;
        logic       rd;
        rst      = 1'b1;
        fifo_rd  = 1'b0;
        rq.req   = '0;
        rq.wdata = '0;
        for (int n = 0; n < N; n++) dat[n] = '0;

        do_reset();
        chk("reset credit", 32'(credit), 32'd16);
        chk("reset err", 32'(err), 32'd0);
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wdata", 32'(wdata_o), 32'd0);

        // Single requester drains all credit in bursts of four.
        dat[0] = 4'd1;
        for (int k = 0; k < 24; k++) begin
            eg = (k < 19 && (k % 5) != 4) ? 4'b0001 : 4'b0000;
            cyc(4'b0001, 1'b0, 1'b0, eg, "A");
        end
        chk("A credit", 32'(credit), 32'd0);

        // All four requesting with one credit returned per write.
        do_reset();
        for (int n = 0; n < N; n++) dat[n] = 4'(n * 4);
        for (int k = 0; k < 40; k++) begin
            eg = ((k % 5) == 4) ? 4'b0000 : (4'b0001 << ((k / 5) % 4));
            rd = (k > 0 && ((k - 1) % 5) != 4);
            cyc(4'b1111, rd, 1'b0, eg, "B");
        end
        cyc(4'b0000, 1'b0, 1'b0, 4'b0000, "B-end");
        chk("B credit", 32'(credit), 32'd16);
        chk("B err", 32'(err), 32'd0);

        // Credit starvation mid-burst for requester 1.
        do_reset();
        dat[0] = 4'd0;
        dat[1] = 4'd10;
        for (int k = 0; k < 17; k++) begin
            eg = ((k % 5) != 4) ? 4'b0001 : 4'b0000;
            cyc(4'b0001, 1'b0, 1'b0, eg, "C-fill");
        end
        chk("C credit2", 32'(credit), 32'd2);
        cyc(4'b0010, 1'b0, 1'b0, 4'b0000, "C-exit");
        cyc(4'b0010, 1'b0, 1'b0, 4'b0010, "C-1a");
        cyc(4'b0010, 1'b0, 1'b0, 4'b0010, "C-1b");
        chk("C credit0", 32'(credit), 32'd0);
        cyc(4'b0010, 1'b0, 1'b0, 4'b0000, "C-stall");
        cyc(4'b0010, 1'b1, 1'b0, 4'b0000, "C-rd");
        chk("C credit1", 32'(credit), 32'd1);
        cyc(4'b0010, 1'b0, 1'b0, 4'b0010, "C-1c");
        cyc(4'b0010, 1'b1, 1'b0, 4'b0000, "C-rd2");
        cyc(4'b0010, 1'b1, 1'b0, 4'b0010, "C-acc+rd");
        chk("C acc+rd credit", 32'(credit), 32'd1);
        chk("C acc+rd wr_en", 32'(wr_en), 32'd1);
        cyc(4'b0011, 1'b0, 1'b0, 4'b0000, "C-cntmax");
        cyc(4'b0011, 1'b0, 1'b0, 4'b0001, "C-wrap");
        chk("C end credit", 32'(credit), 32'd0);

        // Credit return with the counter already full.
        do_reset();
        chk("D err pre", 32'(err), 32'd0);
        cyc(4'b0000, 1'b1, 1'b0, 4'b0000, "D-rdfull");
        chk("D err set", 32'(err), 32'd1);
        chk("D credit", 32'(credit), 32'd16);
        for (int k = 0; k < 3; k++) cyc(4'b0000, 1'b0, 1'b0, 4'b0000, "D-hold");
        chk("D err sticky", 32'(err), 32'd1);
        do_reset();
        chk("D err cleared", 32'(err), 32'd0);

        // Reset on the third word of a burst.
        dat[0] = 4'd5;
        dat[1] = 4'd9;
        cyc(4'b0001, 1'b0, 1'b0, 4'b0001, "E-w1");
        cyc(4'b0001, 1'b0, 1'b0, 4'b0001, "E-w2");
        cyc(4'b0001, 1'b0, 1'b1, 4'b0000, "E-rst");
        chk("E wr_en", 32'(wr_en), 32'd0);
        chk("E credit", 32'(credit), 32'd16);
        cyc(4'b0011, 1'b0, 1'b0, 4'b0001, "E-ptr0");
        cyc(4'b0000, 1'b0, 1'b0, 4'b0000, "E-end");
        cyc(4'b0000, 1'b0, 1'b0, 4'b0000, "E-end");
        chk("queue drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
